// File: rtl/timer_generic_if.sv
// Register-bus bundle for timer_generic: memory-map byte writes, read strobes,
// the external clock pin and the register/interrupt outputs.
interface timer_generic_if;
   logic [7:0] wr_data;
   logic       tcnt_h_we;
   logic       tcnt_l_we;
   logic       ocr_h_we;
   logic       ocr_l_we;
   logic       tccr_we;
   logic       timsk_we;
   logic       tifr_we;
   logic       tcnt_l_rd;
   logic       t_pin;
   logic       irq_ack_ovf;
   logic       irq_ack_cmp;
   logic [7:0] tcnt_h_o;
   logic [7:0] tcnt_l_o;
   logic [7:0] ocr_h_o;
   logic [7:0] ocr_l_o;
   logic [7:0] tccr_o;
   logic [7:0] timsk_o;
   logic [7:0] tifr_o;
   logic       oc_o;
   logic       irq_ovf;
   logic       irq_cmp;

   // Handshake: no valid/ready; every *_we / *_rd / irq_ack_* is a one-cycle
   // strobe sampled at the rising edge, and outputs reflect registers directly.
   modport master (
      output wr_data, tcnt_h_we, tcnt_l_we, ocr_h_we, ocr_l_we, tccr_we,
             timsk_we, tifr_we, tcnt_l_rd, t_pin, irq_ack_ovf, irq_ack_cmp,
      input  tcnt_h_o, tcnt_l_o, ocr_h_o, ocr_l_o, tccr_o, timsk_o, tifr_o,
             oc_o, irq_ovf, irq_cmp
   );

   modport slave (
      input  wr_data, tcnt_h_we, tcnt_l_we, ocr_h_we, ocr_l_we, tccr_we,
             timsk_we, tifr_we, tcnt_l_rd, t_pin, irq_ack_ovf, irq_ack_cmp,
      output tcnt_h_o, tcnt_l_o, ocr_h_o, ocr_l_o, tccr_o, timsk_o, tifr_o,
             oc_o, irq_ovf, irq_cmp
   );
endinterface

// File: rtl/timer_generic.sv
// 8/16-bit timer: prescaled or external clock, Normal/CTC modes, compare toggle
// output and write-1-to-clear flags; 16-bit variant uses a shared TEMP byte.
module timer_generic #(
   parameter int WIDTH = 8
) (
   input  logic            sysClock,
   input  logic            rst_n,
   timer_generic_if.slave  bus
);

   localparam logic [WIDTH-1:0] MAX = '1;

   logic [WIDTH-1:0] r_tcnt;
   logic [WIDTH-1:0] r_ocr;
   logic [WIDTH-1:0] w_tcnt_wr_val;
   logic [WIDTH-1:0] w_ocr_wr_val;
   logic [7:0]       r_tccr;
   logic [7:0]       r_timsk;
   logic [9:0]       r_psc;
   logic             r_tov;
   logic             r_ocf;
   logic             r_oc;
   logic             r_sync1;
   logic             r_sync2;
   logic             r_edge;
   logic             w_rise;
   logic             w_fall;
   logic             w_tick;
   logic             w_tick_eff;
   logic             w_match;
   logic             w_tov_set;
   logic             w_ctc;
   logic             w_com;

   assign w_ctc  = r_tccr[3];
   assign w_com  = r_tccr[4];
   assign w_rise = r_sync2 & ~r_edge;
   assign w_fall = ~r_sync2 & r_edge;

   always_comb begin
      w_tick = 1'b0;
      case (r_tccr[2:0])
         3'd1:    w_tick = 1'b1;
         3'd2:    w_tick = &r_psc[2:0];
         3'd3:    w_tick = &r_psc[5:0];
         3'd4:    w_tick = &r_psc[7:0];
         3'd5:    w_tick = &r_psc;
         3'd6:    w_tick = w_fall;
         3'd7:    w_tick = w_rise;
         default: w_tick = 1'b0;
      endcase
   end

   // A CPU write to TCNT swallows the tick, and with it any compare match.
   always_comb begin
      w_tick_eff = w_tick & ~bus.tcnt_l_we;
      w_match    = w_tick_eff & (r_tcnt == r_ocr);
      if (w_ctc) w_tov_set = w_match & (r_ocr == MAX);
      else       w_tov_set = w_tick_eff & (r_tcnt == MAX);
   end

   always_ff @(posedge sysClock or negedge rst_n) begin
      if (!rst_n) begin
         r_psc   <= '0;
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_edge  <= 1'b0;
         r_tcnt  <= '0;
         r_ocr   <= '0;
         r_tccr  <= '0;
         r_timsk <= '0;
         r_tov   <= 1'b0;
         r_ocf   <= 1'b0;
         r_oc    <= 1'b0;
      end else begin
         r_psc   <= r_psc + 10'd1;
         r_sync1 <= bus.t_pin;
         r_sync2 <= r_sync1;
         r_edge  <= r_sync2;
         if (bus.tcnt_l_we)
            r_tcnt <= w_tcnt_wr_val;
         else if (w_tick_eff)
            r_tcnt <= (w_ctc && w_match) ? '0 : r_tcnt + WIDTH'(1);
         if (bus.ocr_l_we) r_ocr   <= w_ocr_wr_val;
         if (bus.tccr_we)  r_tccr  <= bus.wr_data;
         if (bus.timsk_we) r_timsk <= bus.wr_data;
         // Hardware set outranks a same-cycle clear.
         r_tov <= w_tov_set | (r_tov & ~(bus.tifr_we & bus.wr_data[0]) & ~bus.irq_ack_ovf);
         r_ocf <= w_match   | (r_ocf & ~(bus.tifr_we & bus.wr_data[1]) & ~bus.irq_ack_cmp);
         if (w_match && w_com) r_oc <= ~r_oc;
      end
   end

   generate
      if (WIDTH == 16) begin : g_w16
         logic [7:0] r_temp;
         always_ff @(posedge sysClock or negedge rst_n) begin
            if (!rst_n)
               r_temp <= '0;
            else if (bus.tcnt_h_we || bus.ocr_h_we)
               r_temp <= bus.wr_data;
            else if (bus.tcnt_l_rd)
               r_temp <= r_tcnt[15:8];
         end
         assign w_tcnt_wr_val = {r_temp, bus.wr_data};
         assign w_ocr_wr_val  = {r_temp, bus.wr_data};
         assign bus.tcnt_h_o  = r_temp;
         assign bus.ocr_h_o   = r_ocr[15:8];
      end else begin : g_w8
         logic w_unused_hi;
         assign w_unused_hi   = bus.tcnt_h_we | bus.ocr_h_we | bus.tcnt_l_rd;
         assign w_tcnt_wr_val = WIDTH'(bus.wr_data);
         assign w_ocr_wr_val  = WIDTH'(bus.wr_data);
         assign bus.tcnt_h_o  = 8'h00;
         assign bus.ocr_h_o   = 8'h00;
      end
   endgenerate

   assign bus.tcnt_l_o = r_tcnt[7:0];
   assign bus.ocr_l_o  = r_ocr[7:0];
   assign bus.tccr_o   = r_tccr;
   assign bus.timsk_o  = r_timsk;
   assign bus.tifr_o   = {6'b0, r_ocf, r_tov};
   assign bus.oc_o     = r_oc;
   assign bus.irq_ovf  = r_tov & r_timsk[0];
   assign bus.irq_cmp  = r_ocf & r_timsk[1];

endmodule

// File: tb/tb_timer_generic.sv
// Directed bench for timer_generic (8-bit and 16-bit instances on shared stimulus);
// expectations are queued per target cycle and checked by a negedge monitor.
module tb_timer_generic;

   localparam int R_TCNT_H = 0, R_TCNT_L = 1, R_OCR_H = 2, R_OCR_L = 3;
   localparam int R_TCCR = 4, R_TIMSK = 5, R_TIFR = 6;
   localparam int P_ACK_OVF = 7, P_ACK_CMP = 8, P_RD = 9;
   localparam int S_TCNT8 = 0, S_TIFR8 = 1, S_OC8 = 2, S_IOVF8 = 3, S_ICMP8 = 4;
   localparam int S_TCNTL16 = 5, S_TEMP16 = 6, S_OCR16 = 7, S_TCCR8 = 8;
   localparam int S_TIMSK8 = 9, S_OCR8 = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   int         cyc = 0;
   int         n_checks = 0;
   int         n_fail = 0;

   logic [7:0] wr_data = 8'h00;
   logic       tcnt_h_we = 0, tcnt_l_we = 0, ocr_h_we = 0, ocr_l_we = 0;
   logic       tccr_we = 0, timsk_we = 0, tifr_we = 0, tcnt_l_rd = 0;
   logic       t_pin = 0, irq_ack_ovf = 0, irq_ack_cmp = 0;

   logic [15:0] exp_q[$];
   int          q_cyc[$];
   int          q_sel[$];
   string       q_name[$];

   timer_generic_if b8();
   timer_generic_if b16();

   assign b8.wr_data      = wr_data;      assign b16.wr_data      = wr_data;
   assign b8.tcnt_h_we    = tcnt_h_we;    assign b16.tcnt_h_we    = tcnt_h_we;
   assign b8.tcnt_l_we    = tcnt_l_we;    assign b16.tcnt_l_we    = tcnt_l_we;
   assign b8.ocr_h_we     = ocr_h_we;     assign b16.ocr_h_we     = ocr_h_we;
   assign b8.ocr_l_we     = ocr_l_we;     assign b16.ocr_l_we     = ocr_l_we;
   assign b8.tccr_we      = tccr_we;      assign b16.tccr_we      = tccr_we;
   assign b8.timsk_we     = timsk_we;     assign b16.timsk_we     = timsk_we;
   assign b8.tifr_we      = tifr_we;      assign b16.tifr_we      = tifr_we;
   assign b8.tcnt_l_rd    = tcnt_l_rd;    assign b16.tcnt_l_rd    = tcnt_l_rd;
   assign b8.t_pin        = t_pin;        assign b16.t_pin        = t_pin;
   assign b8.irq_ack_ovf  = irq_ack_ovf;  assign b16.irq_ack_ovf  = irq_ack_ovf;
   assign b8.irq_ack_cmp  = irq_ack_cmp;  assign b16.irq_ack_cmp  = irq_ack_cmp;

   timer_generic #(.WIDTH(8))  u_dut8  (.sysClock(clk), .rst_n(rst_n), .bus(b8));
   timer_generic #(.WIDTH(16)) u_dut16 (.sysClock(clk), .rst_n(rst_n), .bus(b16));

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] observe(input int sel);
      case (sel)
         S_TCNT8:   return {b8.tcnt_h_o, b8.tcnt_l_o};
         S_TIFR8:   return {8'h00, b8.tifr_o};
         S_OC8:     return {15'h0, b8.oc_o};
         S_IOVF8:   return {15'h0, b8.irq_ovf};
         S_ICMP8:   return {15'h0, b8.irq_cmp};
         S_TCNTL16: return {8'h00, b16.tcnt_l_o};
         S_TEMP16:  return {8'h00, b16.tcnt_h_o};
         S_OCR16:   return {b16.ocr_h_o, b16.ocr_l_o};
         S_TCCR8:   return {8'h00, b8.tccr_o};
         S_TIMSK8:  return {8'h00, b8.timsk_o};
         S_OCR8:    return {b8.ocr_h_o, b8.ocr_l_o};
         default:   return 16'hxxxx;
      endcase
   endfunction

   // scoreboard monitor
   always @(negedge clk) begin : monitor
      logic [15:0] got;
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
         if (q_cyc[i] <= cyc) begin
            got = observe(q_sel[i]);
            n_checks++;
            if (q_cyc[i] < cyc || got !== exp_q[i]) begin
               n_fail++;
               $display("FAIL %0s @cyc %0d (checked %0d): got %h expected %h",
                        q_name[i], q_cyc[i], cyc, got, exp_q[i]);
            end
            exp_q.delete(i);
            q_cyc.delete(i);
            q_sel.delete(i);
            q_name.delete(i);
         end
      end
   end

   task automatic push_exp(input int c, input int sel, input logic [15:0] v, input string nm);
      exp_q.push_back(v);
      q_cyc.push_back(c);
      q_sel.push_back(sel);
      q_name.push_back(nm);
   endtask

   task automatic go_to(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_strobes();
      tcnt_h_we = 0; tcnt_l_we = 0; ocr_h_we = 0; ocr_l_we = 0;
      tccr_we = 0; timsk_we = 0; tifr_we = 0; tcnt_l_rd = 0;
      irq_ack_ovf = 0; irq_ack_cmp = 0;
   endtask

   // drive one strobe for the next edge; returns #1 after that edge
   task automatic wr(input int r, input logic [7:0] v);
      wr_data = v;
      case (r)
         R_TCNT_H:  tcnt_h_we = 1;
         R_TCNT_L:  tcnt_l_we = 1;
         R_OCR_H:   ocr_h_we = 1;
         R_OCR_L:   ocr_l_we = 1;
         R_TCCR:    tccr_we = 1;
         R_TIMSK:   timsk_we = 1;
         R_TIFR:    tifr_we = 1;
         P_ACK_OVF: irq_ack_ovf = 1;
         P_ACK_CMP: irq_ack_cmp = 1;
         P_RD:      tcnt_l_rd = 1;
         default:   ;
      endcase
      @(posedge clk);
      #1;
      clear_strobes();
   endtask

   initial begin : stimulus
      int e, r0, p, c0, c1;
      // reset
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      push_exp(cyc, S_TCNT8, 16'h0000, "rst_tcnt");
      push_exp(cyc, S_TIFR8, 16'h0000, "rst_tifr");
      push_exp(cyc, S_OC8,   16'h0000, "rst_oc");
      push_exp(cyc, S_IOVF8, 16'h0000, "rst_irq_ovf");
      push_exp(cyc, S_ICMP8, 16'h0000, "rst_irq_cmp");

      // register read-back
      wr(R_TCCR, 8'hE0);  push_exp(cyc, S_TCCR8,  16'h00E0, "tccr_rb");
      wr(R_TIMSK, 8'hFC); push_exp(cyc, S_TIMSK8, 16'h00FC, "timsk_rb");
      wr(R_TIFR, 8'hFF);  push_exp(cyc, S_TIFR8,  16'h0000, "tifr_rb");

      // Normal-mode overflow from 0xFD
      wr(R_TIMSK, 8'h01);
      wr(R_TCNT_L, 8'hFD);
      wr(R_TCCR, 8'h01);
      e = cyc;
      push_exp(e + 1, S_TCNT8, 16'h00FE, "ovf_fe");
      push_exp(e + 2, S_TCNT8, 16'h00FF, "ovf_ff");
      push_exp(e + 2, S_IOVF8, 16'h0000, "ovf_irq_pre");
      push_exp(e + 3, S_TCNT8, 16'h0000, "ovf_wrap");
      push_exp(e + 3, S_TIFR8, 16'h0001, "ovf_tov");
      push_exp(e + 3, S_IOVF8, 16'h0001, "ovf_irq");
      go_to(e + 3);
      wr(R_TIFR, 8'h01);
      push_exp(e + 4, S_TIFR8, 16'h0002, "ovf_w1c_ocf0");
      push_exp(e + 4, S_IOVF8, 16'h0000, "ovf_irq_clr");
      wr(R_TCCR, 8'h00);
      wr(R_TIFR, 8'h03);

      // CTC with compare toggle and set-vs-clear races
      wr(R_TCNT_L, 8'h00);
      wr(R_OCR_L, 8'h04);
      wr(R_TIFR, 8'h03);
      wr(R_TIMSK, 8'h02);
      wr(R_TCCR, 8'h19);
      e = cyc;
      push_exp(e + 1, S_TCNT8, 16'h0001, "ctc_1");
      push_exp(e + 2, S_TCNT8, 16'h0002, "ctc_2");
      push_exp(e + 3, S_TCNT8, 16'h0003, "ctc_3");
      push_exp(e + 4, S_TCNT8, 16'h0004, "ctc_4");
      push_exp(e + 4, S_TIFR8, 16'h0000, "ctc_ocf_pre");
      push_exp(e + 4, S_OC8,   16'h0000, "ctc_oc_pre");
      push_exp(e + 5, S_TCNT8, 16'h0000, "ctc_clr");
      push_exp(e + 5, S_TIFR8, 16'h0002, "ctc_ocf");
      push_exp(e + 5, S_ICMP8, 16'h0001, "ctc_irq");
      push_exp(e + 5, S_OC8,   16'h0001, "ctc_oc1");
      push_exp(e + 9, S_OC8,   16'h0001, "ctc_oc_hold");
      push_exp(e + 10, S_OC8,  16'h0000, "ctc_oc2");
      push_exp(e + 10, S_TIFR8, 16'h0002, "ctc_no_tov");
      go_to(e + 11);
      wr(R_TIFR, 8'h02);
      push_exp(e + 12, S_TIFR8, 16'h0000, "w1c_ocf");
      push_exp(e + 14, S_TIFR8, 16'h0000, "w1c_ocf_hold");
      go_to(e + 14);
      wr(R_TIFR, 8'h02);
      push_exp(e + 15, S_TIFR8, 16'h0002, "race_w1c");
      go_to(e + 16);
      wr(R_TIFR, 8'h02);
      push_exp(e + 17, S_TIFR8, 16'h0000, "w1c_ocf2");
      go_to(e + 19);
      wr(P_ACK_CMP, 8'h00);
      push_exp(e + 20, S_TIFR8, 16'h0002, "race_ack");
      push_exp(e + 20, S_OC8,   16'h0000, "ctc_oc4");
      wr(P_ACK_CMP, 8'h00);
      push_exp(e + 21, S_TIFR8, 16'h0000, "ack_clr");
      push_exp(e + 21, S_ICMP8, 16'h0000, "ack_irq_clr");

      // asynchronous reset mid-count
      rst_n = 1'b0;
      clear_strobes();
      push_exp(cyc, S_TCNT8, 16'h0000, "arst_tcnt");
      push_exp(cyc, S_TCCR8, 16'h0000, "arst_tccr");
      push_exp(cyc, S_OC8,   16'h0000, "arst_oc");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      r0 = cyc;

      // prescaler /64 counted from reset
      wr(R_TCCR, 8'h03);
      push_exp(r0 + 63,  S_TCNT8, 16'h0000, "psc_63");
      push_exp(r0 + 64,  S_TCNT8, 16'h0001, "psc_64");
      push_exp(r0 + 127, S_TCNT8, 16'h0001, "psc_127");
      push_exp(r0 + 128, S_TCNT8, 16'h0002, "psc_128");
      go_to(r0 + 129);
      wr(R_TCCR, 8'h00);
      push_exp(r0 + 200, S_TCNT8, 16'h0002, "psc_frozen");
      go_to(r0 + 200);

      // external rising-edge clock
      wr(R_TCNT_L, 8'h00);
      wr(R_TCCR, 8'h07);
      p = cyc + 2;
      push_exp(p + 2,  S_TCNT8, 16'h0000, "ext_lat");
      push_exp(p + 3,  S_TCNT8, 16'h0001, "ext_1");
      push_exp(p + 10, S_TCNT8, 16'h0001, "ext_fall_ign");
      push_exp(p + 11, S_TCNT8, 16'h0002, "ext_2");
      push_exp(p + 18, S_TCNT8, 16'h0002, "ext_lat3");
      push_exp(p + 19, S_TCNT8, 16'h0003, "ext_3");
      push_exp(p + 24, S_TCNT8, 16'h0003, "ext_end");
      for (int k = 0; k < 6; k++) begin
         go_to(p + 4 * k);
         t_pin = (k % 2 == 0);
      end
      go_to(p + 24);

      // TCNT write during a tick with a pending compare match
      wr(R_TCCR, 8'h00);
      wr(R_OCR_L, 8'h10);
      wr(R_TIFR, 8'h03);
      wr(R_TCNT_L, 8'h0E);
      c0 = cyc;
      wr(R_TCCR, 8'h01);
      push_exp(c0 + 2, S_TCNT8, 16'h000F, "wvt_0f");
      push_exp(c0 + 3, S_TCNT8, 16'h0010, "wvt_10");
      go_to(c0 + 3);
      wr(R_TCNT_L, 8'h40);
      push_exp(c0 + 4, S_TCNT8, 16'h0040, "wvt_write");
      push_exp(c0 + 4, S_TIFR8, 16'h0000, "wvt_no_match");
      push_exp(c0 + 5, S_TCNT8, 16'h0041, "wvt_next");
      wr(R_TCCR, 8'h00);

      // 16-bit TEMP access
      wr(R_TCNT_H, 8'h12);
      wr(R_TCNT_L, 8'h34);
      push_exp(cyc, S_TCNTL16, 16'h0034, "t16_lo");
      push_exp(cyc, S_TCNT8,   16'h0034, "t8_hi_ign");
      wr(P_RD, 8'h00);
      push_exp(cyc, S_TEMP16, 16'h0012, "t16_rd_hi");
      wr(R_OCR_H, 8'hAB);
      wr(R_OCR_L, 8'hCD);
      push_exp(cyc, S_OCR16, 16'hABCD, "ocr16");
      push_exp(cyc, S_OCR8,  16'h00CD, "ocr8");
      wr(R_TCNT_H, 8'h12);
      wr(R_TCNT_L, 8'hFD);
      c1 = cyc;
      wr(R_OCR_H, 8'h55);
      push_exp(c1 + 1, S_TEMP16, 16'h0055, "t16_temp55");
      wr(R_TCCR, 8'h01);
      go_to(c1 + 4);
      push_exp(c1 + 4, S_TCNTL16, 16'h00FF, "t16_ff");
      push_exp(c1 + 4, S_TEMP16,  16'h0055, "t16_temp_hold");
      wr(P_RD, 8'h00);
      push_exp(c1 + 5, S_TCNTL16, 16'h0000, "t16_wrap_lo");
      push_exp(c1 + 5, S_TEMP16,  16'h0012, "t16_latched");
      push_exp(c1 + 8, S_TCNTL16, 16'h0003, "t16_run");
      push_exp(c1 + 8, S_TEMP16,  16'h0012, "t16_atomic");
      go_to(c1 + 8);
      wr(R_TCCR, 8'h00);

      // drain the scoreboard, bounded
      for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         $display("FAIL drain: %0d expectations never checked, required 0", exp_q.size());
         n_checks += exp_q.size();
         n_fail += exp_q.size();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/timer_generic.md
# timer_generic

Parametrised successor to the fixed 8-bit and 16-bit timers: one counter block, WIDTH 8 or 16, with a shared-style prescaler, Normal and CTC modes, an external clock-pin source, a compare-toggle output and write-1-to-clear interrupt flags. It sits on the I/O side of the memory map. Byte-wide register writes come from the memory-map write-data and write-enable bus. Register outputs feed the I/O concatenation bus, and the interrupt requests go to the control unit. For WIDTH=16, a TEMP high-byte latch gives atomic 16-bit TCNT and OCR access.

## Interface
- WIDTH, 8: counter width; legal values are 8 and 16 only.
- sysClock  in  1  system clock (16 MHz).
- rst_n  in  1  reset; asynchronous, active-low.
- wr_data  in  8  memory-map write data.
- tcnt_h_we, tcnt_l_we, ocr_h_we, ocr_l_we  in  1 each  byte write enables.
- tccr_we, timsk_we, tifr_we  in  1 each  control, mask and flag write enables.
- tcnt_l_rd  in  1  CPU read strobe of the TCNT low byte.
- t_pin  in  1  asynchronous external clock pin.
- irq_ack_ovf, irq_ack_cmp  in  1 each  vector-entry acknowledge; clears the corresponding flag.
- tcnt_h_o, tcnt_l_o, ocr_h_o, ocr_l_o  out  8 each  register reads.
- tccr_o, timsk_o, tifr_o  out  8 each  register reads.
- oc_o  out  1  compare output.
- irq_ovf, irq_cmp  out  1 each  interrupt requests.

## Operation
- TCCR[2:0] CS selects the clock source:
  - 0: stopped.
  - 1: clk/1.
  - 2: /8.
  - 3: /64.
  - 4: /256.
  - 5: /1024.
  - 6: t_pin falling edge.
  - 7: t_pin rising edge.
- TCCR[3] WGM: 0 = Normal, 1 = CTC. TCCR[4] COM: 1 = toggle oc_o on compare match. TCCR[7:5] are stored and read back.
- TIMSK[0] TOIE, TIMSK[1] OCIE; other bits are stored. TIFR[0] TOV, TIFR[1] OCF; bits [7:2] read 0.
- Prescaler: free-running 10-bit counter `psc`.
  - Never reset by TCCR writes.
  - A tick for /N fires in the cycle where `psc[log2(N)-1:0]` is all ones.
- External source:
  - t_pin passes through a 2-flop synchroniser and then an edge-detect flop.
  - A tick is issued in the cycle an edge is detected.
- On tick, Normal mode:
  - If TCNT == OCR, set OCF.
  - If TCNT == MAX (2^WIDTH−1), set TOV and wrap TCNT to 0; otherwise increment TCNT.
- On tick, CTC mode:
  - If TCNT == OCR, set OCF and clear TCNT to 0.
  - TOV is set only when OCR == MAX, on that clear.
- Compares use the pre-increment TCNT value. oc_o toggles on every OCF set event when COM=1.
- CPU write to TCNT:
  - The write wins over a same-cycle tick; that tick is discarded.
  - Compare match is suppressed for that cycle.
- Flags:
  - Writing 1 to a TIFR bit clears it; writing 0 has no effect.
  - irq_ack_* clears the corresponding flag.
  - A hardware set in the same cycle as a clear wins (flag stays 1).
- irq_ovf = TOV & TOIE and irq_cmp = OCF & OCIE, both combinational from registers.
- WIDTH=16, single shared 8-bit TEMP latch:
  - tcnt_h_we or ocr_h_we writes TEMP only.
  - tcnt_l_we loads TCNT = {TEMP, wr_data}; ocr_l_we loads OCR = {TEMP, wr_data}.
  - tcnt_l_rd latches TCNT[15:8] into TEMP; tcnt_h_o outputs TEMP.
  - ocr_h_o outputs OCR[15:8] directly.
  - If a high-byte write and tcnt_l_rd occur in the same cycle, the write wins.
- WIDTH=8:
  - No TEMP; tcnt_l_we and ocr_l_we write directly.
  - High-byte writes are ignored; tcnt_h_o and ocr_h_o read 0.

## Timing
- Reset, immediate and asynchronous:
  - TCNT, OCR, TEMP, TCCR, TIMSK, TIFR, psc, synchroniser and edge flops = 0.
  - oc_o = 0 and irq_* = 0.
- All register writes take effect at the rising edge where the enable is high; read-back is visible the next cycle.
- CS=1: TCNT advances every cycle.
- CS=2: first tick when psc = 7 after reset, i.e. the 8th edge, then every 8 cycles.
- External edge to TCNT change: 3 sysClock edges (2 sync + 1 edge-detect); minimum pin pulse is 1 clock period each level.
- Flags, oc_o and the TCNT update share one edge. irq_* rise in the same cycle the flag becomes 1.
- Reset mid-count aborts everything; counting resumes only after a CS write.

## Test plan
- Overflow: WIDTH=8, CS=1, TCNT=0xFD, TOIE=1 → TCNT 0xFE, 0xFF, 0x00 on successive edges; TOV and irq_ovf high on the wrap edge; write TIFR=0x01 → both low next cycle.
- CTC: CS=1, WGM=1, COM=1, OCR=4 → TCNT sequence 0,1,2,3,4,0 (period 5); OCF sets and oc_o toggles on each 4→0 edge; TOV stays 0.
- Prescaler: CS=3 from reset → TCNT reaches 1 after 64 edges, 2 after 128; switching CS to 0 freezes TCNT.
- External: CS=7, three rising edges on t_pin → TCNT=3, each increment 3 edges after its pin edge; falling edges ignored.
- 16-bit atomic access: WIDTH=16, write H=0x12 then L=0x34 → TCNT=0x1234. Pulse tcnt_l_rd at TCNT=0x12FF → tcnt_h_o holds 0x12 after TCNT wraps past 0x1300.
- Races:
  - Set vs clear: compare match in the same cycle as a TIFR=0x02 write, and again as irq_ack_cmp → OCF remains 1 in both cases.
  - Write vs tick: TCNT write during a tick → TCNT equals the written value, not value+1.
